// File: rtl/lsu_dmem_master.sv
// Load/store unit driving a word-wide dmem: sub-word stores by read-modify-write, loads sign/zero-extended.
// Optional address range check enabled by defining LSU_BOUND_CHECK_EN.
module lsu_dmem_master #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  output logic [1:0]  dbg_state_o
);

  // Handshake: a request is taken on a rising edge where req_valid_i && req_ready_o;
  // req_ready_o is high only in IDLE. resp_valid_o is a one-cycle pulse with no backpressure.

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

`ifdef LSU_BOUND_CHECK_EN
  localparam bit BoundCheck = 1'b1;
`else
  localparam bit BoundCheck = 1'b0;
`endif
  localparam logic [32:0] MemLimit = 33'(MEM_BYTES);

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] word_q, word_d;
  logic        err_q, err_d;

  logic        misalign;
  logic        req_bad;
  logic [31:0] byte_sh, half_sh, load_val, merged;

  always_comb begin
    misalign = 1'b0;
    case (req_size_i)
      SZ_BYTE: misalign = 1'b0;
      SZ_HALF: misalign = req_addr_i[0];
      SZ_WORD: misalign = |req_addr_i[1:0];
      default: misalign = 1'b1;
    endcase
    req_bad = misalign || (BoundCheck && ({1'b0, req_addr_i} >= MemLimit));
  end

  // Lane extraction and merge both work on the word captured in READ.
  always_comb begin
    byte_sh  = word_q >> {addr_q[1:0], 3'b000};
    half_sh  = word_q >> {addr_q[1], 4'b0000};
    load_val = word_q;
    merged   = word_q;
    case (size_q)
      SZ_BYTE: begin
        load_val = uns_q ? {24'h0, byte_sh[7:0]} : {{24{byte_sh[7]}}, byte_sh[7:0]};
        merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      end
      SZ_HALF: begin
        load_val = uns_q ? {16'h0, half_sh[15:0]} : {{16{half_sh[15]}}, half_sh[15:0]};
        merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    size_d       = size_q;
    uns_d        = uns_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    word_d       = word_q;
    err_d        = err_q;
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    resp_rdata_o = 32'h0;
    resp_err_o   = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = 32'h0;
    mem_wdata_o  = 32'h0;
    case (state_q)
      S_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          we_d    = req_we_i;
          size_d  = req_size_i;
          uns_d   = req_unsigned_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          err_d   = req_bad;
          if (req_bad)                             state_d = S_RESP;
          else if (req_we_i && req_size_i == SZ_WORD) state_d = S_WRITE;
          else                                     state_d = S_READ;
        end
      end
      S_READ: begin
        mem_addr_o = {addr_q[31:2], 2'b00};
        word_d     = mem_rdata_i;
        state_d    = we_q ? S_WRITE : S_RESP;
      end
      S_WRITE: begin
        mem_addr_o  = {addr_q[31:2], 2'b00};
        mem_we_o    = 1'b1;
        mem_wdata_o = (size_q == SZ_WORD) ? wdata_q : merged;
        state_d     = S_RESP;
      end
      S_RESP: begin
        mem_addr_o   = {addr_q[31:2], 2'b00};
        resp_valid_o = 1'b1;
        resp_err_o   = err_q;
        resp_rdata_o = (err_q || we_q) ? 32'h0 : load_val;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      word_q  <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
      err_q   <= err_d;
    end
  end

  assign dbg_state_o = state_q;

endmodule
